// File: rtl/sram_like_to_axi_pkg.sv
// -----------------------------------------------------------------------------
// includes
//   Shared widths, AXI encodings and the bridge state type used by
//   sram_like_to_axi and its strobe generator.
// -----------------------------------------------------------------------------
package includes;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B
    } axi_state_t;

    // sram-like size code 3 has no AXI meaning here; it is treated as a word.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return (size == 2'd3) ? AXI_SIZE_WORD : {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_like_to_axi_byte_strobe_gen.sv
// -----------------------------------------------------------------------------
// byte_strobe_gen
//   Combinational AXI write strobe from the sram-like size code and the low
//   two address bits.
//   size_i    : 0 byte, 1 half, 2/3 word
//   addr_lo_i : addr[1:0]
//   wstrb_o   : byte-lane enables
// -----------------------------------------------------------------------------
module byte_strobe_gen (
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    always_comb begin
        case (size_i)
            2'd0:    wstrb_o = 4'b0001 << addr_lo_i;
            // Half-words are aligned on a 2-byte boundary; addr[0] is ignored.
            2'd1:    wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            default: wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_to_axi.sv
// -----------------------------------------------------------------------------
// sram_like_to_axi
//   Converts one sram-like request at a time into a single-beat AXI4 read
//   (AR/R) or write (AW/W/B). Completion is signalled on data_ok.
//   clk, rst (async, active-low)
//   sram-like side : req, wr, size, addr, wdata -> addr_ok, data_ok, rdata
//   AXI AR/R       : araddr..arvalid/arready, rdata_axi/rresp/rlast/rvalid/rready
//   AXI AW/W/B     : awaddr..awvalid/awready, wdata_axi/wstrb/wlast/wvalid/wready,
//                    bresp/bvalid/bready
// -----------------------------------------------------------------------------
module sram_like_to_axi
    import includes::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    // sram-like slave port
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [W_ADDR-1:0] addr,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] rdata,
    output logic              addr_ok,
    output logic              data_ok,
    // AXI read address / data
    output logic [W_ADDR-1:0] araddr,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    output logic              arvalid,
    input  logic              arready,
    input  logic [W_DATA-1:0] rdata_axi,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address / data / response
    output logic [W_ADDR-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic [7:0]        awlen,
    output logic [1:0]        awburst,
    output logic [3:0]        awid,
    output logic              awvalid,
    input  logic              awready,
    output logic [W_DATA-1:0] wdata_axi,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    axi_state_t        state_q;
    logic [1:0]        size_q;
    logic [W_ADDR-1:0] addr_q;
    logic [W_DATA-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [3:0]        strobe_d;
    logic              aw_fin, w_fin;

    // Responses are not reported and single beats make rlast redundant.
    logic unused_inputs;
    assign unused_inputs = ^{rresp, bresp, rlast};

    byte_strobe_gen u_strobe (
        .size_i    (size),
        .addr_lo_i (addr[1:0]),
        .wstrb_o   (strobe_d)
    );

    // In WR_AW a cleared awvalid_q/wvalid_q is the "channel done" flag; a
    // handshake in the current cycle also counts so both orders and the
    // simultaneous case leave WR_AW on the same edge.
    assign aw_fin = ~awvalid_q | awready;
    assign w_fin  = ~wvalid_q  | wready;

    // NOTE: state registers use non-blocking assignments so every branch sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wstrb_q <= strobe_d;
                        if (wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR_AW: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake-facing sram-like outputs are combinational so a zero-wait
    // slave completes in three cycles.
    assign addr_ok = req & rst & (state_q == IDLE);
    assign data_ok = ((state_q == RD_D) & rvalid) | ((state_q == WR_B) & bvalid);
    assign rdata   = rdata_axi;

    assign araddr  = addr_q;
    assign arsize  = axi_size(size_q);
    assign arlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;
    assign arid    = AXI_ID;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awaddr    = addr_q;
    assign awsize    = axi_size(size_q);
    assign awlen     = 8'd0;
    assign awburst   = AXI_BURST_INCR;
    assign awid      = AXI_ID;
    assign awvalid   = awvalid_q;
    assign wdata_axi = wdata_q;
    assign wstrb     = wstrb_q;
    assign wlast     = 1'b1;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_sram_like_to_axi.sv
// -----------------------------------------------------------------------------
// tb_sram_like_to_axi
//   Directed bench: a scripted AXI slave with hand-computed expectations.
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_sram_like_to_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        addr_ok, data_ok;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst;
    logic [3:0]  arid, awid;
    logic        arvalid, awvalid, wvalid, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic        rvalid = 1'b0, bvalid = 1'b0, rlast = 1'b1;
    logic [31:0] rdata_axi = '0;
    logic [1:0]  rresp = 2'd0, bresp = 2'd0;
    logic [31:0] wdata_axi;
    logic [3:0]  wstrb;
    logic        wlast;

    int n_checks = 0;
    int n_errors = 0;

    // Running event counters, sampled on the falling edge.
    int arv_cnt = 0, aw_hs = 0, w_hs = 0, dok_cnt = 0, overlap = 0;
    int b_arv, b_aw, b_w, b_dok;

    always #5 clk = ~clk;

    sram_like_to_axi #(.AXI_ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .arid(arid), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always @(negedge clk) begin
        if (rst) begin
            arv_cnt <= arv_cnt + int'(arvalid);
            aw_hs   <= aw_hs + int'(awvalid & awready);
            w_hs    <= w_hs + int'(wvalid & wready);
            dok_cnt <= dok_cnt + int'(data_ok);
            overlap <= overlap + int'(arvalid & awvalid);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic snap();
        b_arv = arv_cnt; b_aw = aw_hs; b_w = w_hs; b_dok = dok_cnt;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    endtask

    initial begin
        // ---------------- reset state ----------------
        req = 1'b1;
        #2;
        check("rst_addr_ok_gated", {31'd0, addr_ok}, 32'd0);
        check("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        check("rst_data_ok", {31'd0, data_ok}, 32'd0);
        check("rst_latched", {wstrb, awaddr[27:0]}, 32'd0);
        check("rst_wdata", wdata_axi, 32'd0);
        req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // ---------------- 1: read word, arready low 2 cycles ----------------
        snap();
        issue(1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
        mid(); check("rd_addr_ok", {31'd0, addr_ok}, 32'd1);
        cyc(); req = 1'b0;
        mid(); check("rd_araddr", araddr, 32'hBFC0_0000);
        check("rd_arsize", {29'd0, arsize}, 32'd2);
        check("rd_arlen_burst_id", {18'd0, arlen, arburst, arid}, {18'd0, 8'd0, 2'b01, 4'h0});
        cyc();
        cyc(); arready = 1'b1;
        mid(); check("rd_arvalid_held", {31'd0, arvalid}, 32'd1);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h1234_5678;
        mid(); check("rd_rready", {31'd0, rready}, 32'd1);
        check("rd_data_ok", {31'd0, data_ok}, 32'd1);
        check("rd_rdata", rdata, 32'h1234_5678);
        cyc(); rvalid = 1'b0;
        mid(); check("rd_after", {29'd0, data_ok, arvalid, rready}, 32'd0);
        cyc();
        check("rd_arvalid_cycles", arv_cnt - b_arv, 32'd3);
        check("rd_one_data_ok", dok_cnt - b_dok, 32'd1);

        // ---------------- 2: byte write at 0x8000_0003 ----------------
        snap();
        issue(1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
        mid(); check("wb_addr_ok", {31'd0, addr_ok}, 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1;
        mid(); check("wb_valids", {30'd0, awvalid, wvalid}, 32'd3);
        check("wb_awaddr", awaddr, 32'h8000_0003);
        check("wb_awsize", {29'd0, awsize}, 32'd0);
        check("wb_wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, 4'b1000, 1'b1});
        check("wb_wdata", wdata_axi, 32'hAB00_0000);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        mid(); check("wb_bready_data_ok", {30'd0, bready, data_ok}, 32'd3);
        cyc(); bvalid = 1'b0;
        mid(); check("wb_data_ok_after_b", {31'd0, data_ok}, 32'd0);
        cyc();
        check("wb_beats", {(aw_hs - b_aw), (w_hs - b_w)}, {32'd1, 32'd1});

        // ---------------- 3: half write, W 3 cycles before AW ----------------
        snap();
        issue(1'b1, 2'd1, 32'h0000_1002, 32'h5A5A_0000);
        cyc(); req = 1'b0; wready = 1'b1;
        mid(); check("wh_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
        cyc(); wready = 1'b0;
        mid(); check("wh_w_dropped", {30'd0, awvalid, wvalid}, 32'd2);
        cyc();
        cyc(); awready = 1'b1;
        mid(); check("wh_aw_still_high", {30'd0, awvalid, wvalid}, 32'd2);
        check("wh_wstrb", {28'd0, wstrb}, 32'hC);
        cyc(); awready = 1'b0; bvalid = 1'b1;
        mid(); check("wh_data_ok", {31'd0, data_ok}, 32'd1);
        cyc(); bvalid = 1'b0;
        check("wh_aw_beats", aw_hs - b_aw, 32'd1);
        check("wh_w_beats", w_hs - b_w, 32'd1);

        // ---------------- 4: back-to-back read then write ----------------
        snap();
        issue(1'b0, 2'd2, 32'h0000_0100, 32'd0);
        cyc(); req = 1'b0; arready = 1'b1;
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D;
        mid(); check("bb_rd_data_ok", {31'd0, data_ok}, 32'd1);
        check("bb_rdata", rdata, 32'hCAFE_F00D);
        cyc(); rvalid = 1'b0;
        issue(1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344);
        mid(); check("bb_second_addr_ok", {31'd0, addr_ok}, 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1;
        mid(); check("bb_wstrb", {28'd0, wstrb}, 32'hF);
        check("bb_awaddr", awaddr, 32'h0000_0200);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        mid(); check("bb_wr_data_ok", {31'd0, data_ok}, 32'd1);
        cyc(); bvalid = 1'b0;
        check("bb_two_data_ok", dok_cnt - b_dok, 32'd2);

        // ---------------- 5: reset during WR_AW ----------------
        issue(1'b1, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF);
        cyc(); req = 1'b0;
        mid(); check("rs_awvalid_before", {31'd0, awvalid}, 32'd1);
        #2 rst = 1'b0; req = 1'b1; wr = 1'b0;
        #1 check("rs_valids_dropped", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        check("rs_addr_ok_gated", {31'd0, addr_ok}, 32'd0);
        req = 1'b0;
        cyc(); rst = 1'b1;
        issue(1'b0, 2'd2, 32'h0000_0400, 32'd0);
        mid(); check("rs_idle_addr_ok", {31'd0, addr_ok}, 32'd1);
        cyc(); req = 1'b0; arready = 1'b1;
        mid(); check("rs_arvalid", {31'd0, arvalid}, 32'd1);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0BAD_CAFE;
        mid(); check("rs_rd_data_ok", {31'd0, data_ok}, 32'd1);
        check("rs_rdata", rdata, 32'h0BAD_CAFE);
        cyc(); rvalid = 1'b0;

        // ---------------- 6: error responses ----------------
        snap();
        issue(1'b1, 2'd0, 32'h0000_0501, 32'h0000_7700);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1;
        mid(); check("er_wstrb_b1", {28'd0, wstrb}, 32'h2);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        mid(); check("er_slverr_data_ok", {31'd0, data_ok}, 32'd1);
        cyc(); bvalid = 1'b0; bresp = 2'b00;
        issue(1'b0, 2'd3, 32'h0000_0600, 32'd0);
        mid(); check("er_idle_after_b", {31'd0, addr_ok}, 32'd1);
        cyc(); req = 1'b0; arready = 1'b1;
        mid(); check("er_size3_word", {29'd0, arsize}, 32'd2);
        cyc(); arready = 1'b0; rvalid = 1'b1; rresp = 2'b11; rdata_axi = 32'h5555_AAAA;
        mid(); check("er_decerr_data_ok", {31'd0, data_ok}, 32'd1);
        cyc(); rvalid = 1'b0; rresp = 2'b00;
        req = 1'b1; wr = 1'b0;
        mid(); check("er_idle_after_r", {31'd0, addr_ok}, 32'd1);
        req = 1'b0;
        cyc();
        check("er_two_data_ok", dok_cnt - b_dok, 32'd2);
        check("no_ar_aw_overlap", overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
